axi_mm_test_seq: RTL and testbench

AXI_MM_TEST_SEQ -- requirements
Module: axi_mm_test_seq

---
 rtl/axi_mm_test_seq.sv | 212 +++++++++++++++++++++
 tb/tb_axi_mm_test_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_test_seq.sv
// AXI-Stream pattern test sequencer.
// Walks the enabled pattern modes (fixed, random, incrementing) in order.
// Each mode runs num_iter times with a gap between runs. Every run launches
// the pattern generator, waits for burst_len accepted beats (or a timeout),
// and checker errors are folded into a pass/fail result at the end.
module axi_mm_test_seq #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 4
) (
  input  logic       wr_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mode_mask,
  input  logic [7:0] burst_len,
  input  logic [3:0] num_iter,
  input  logic       axist_valid,
  input  logic       axist_rdy,
  input  logic       chkr_err,
  output logic       patgen_en,
  output logic [1:0] patgen_sel,
  output logic [7:0] patgen_cnt,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_timeout,
  output logic       err_cfg,
  output logic [7:0] run_cnt
);

  // A gap shorter than one cycle is not meaningful; clamp it to one.
  localparam int GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int TO_N  = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
  localparam int TW    = $clog2(TO_N + 1);
  localparam int GW    = $clog2(GAP_N + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TO_N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  logic [2:0]      r_mask;
  logic [7:0]      r_len;
  logic [3:0]      r_iter_cfg;
  logic [3:0]      r_iter;
  logic [1:0]      r_mode;
  logic [7:0]      r_beats;
  logic [TW-1:0]   r_tmo;
  logic [GW-1:0]   r_gap;
  logic            r_chk_err;
  logic            r_patgen_en;
  logic [1:0]      r_patgen_sel;
  logic [7:0]      r_patgen_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_err_timeout;
  logic            r_err_cfg;
  logic [7:0]      r_run_cnt;

  logic [2:0]      w_first;
  logic [2:0]      w_next;
  logic [3:0]      w_iter_last;
  logic            w_beat;

  // Lowest set mode bit: {found, mode}.
  function automatic logic [2:0] first_mode(input logic [2:0] mask);
    logic [2:0] res;
    res = 3'b000;
    if (mask[0])      res = 3'b100;
    else if (mask[1]) res = 3'b101;
    else if (mask[2]) res = 3'b110;
    return res;
  endfunction

  // Next enabled mode strictly after the current one: {found, mode}.
  function automatic logic [2:0] next_mode(input logic [2:0] mask, input logic [1:0] cur);
    logic [2:0] above;
    case (cur)
      2'd0:    above = mask & 3'b110;
      2'd1:    above = mask & 3'b100;
      default: above = 3'b000;
    endcase
    return first_mode(above);
  endfunction

  assign w_first     = first_mode(mode_mask);
  assign w_next      = next_mode(r_mask, r_mode);
  // num_iter of zero behaves as a single iteration.
  assign w_iter_last = (r_iter_cfg == 4'd0) ? 4'd0 : r_iter_cfg - 4'd1;
  assign w_beat      = axist_valid && axist_rdy;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mask        <= 3'd0;
      r_len         <= 8'd0;
      r_iter_cfg    <= 4'd0;
      r_iter        <= 4'd0;
      r_mode        <= 2'd0;
      r_beats       <= 8'd0;
      r_tmo         <= '0;
      r_gap         <= '0;
      r_chk_err     <= 1'b0;
      r_patgen_en   <= 1'b0;
      r_patgen_sel  <= 2'd0;
      r_patgen_cnt  <= 8'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_cfg     <= 1'b0;
      r_run_cnt     <= 8'd0;
    end else begin
      r_patgen_en <= 1'b0;
      r_done      <= 1'b0;
      if (r_state != S_IDLE && chkr_err) r_chk_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask        <= mode_mask;
            r_len         <= burst_len;
            r_iter_cfg    <= num_iter;
            r_iter        <= 4'd0;
            r_run_cnt     <= 8'd0;
            r_err_timeout <= 1'b0;
            r_chk_err     <= 1'b0;
            r_pass        <= 1'b0;
            r_busy        <= 1'b1;
            if (mode_mask == 3'd0 || burst_len == 8'd0) begin
              r_err_cfg <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_err_cfg    <= 1'b0;
              r_mode       <= w_first[1:0];
              r_patgen_sel <= w_first[1:0];
              r_patgen_cnt <= burst_len;
              r_patgen_en  <= 1'b1;
              r_state      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_beats <= 8'd0;
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_beat) r_beats <= r_beats + 8'd1;
          r_tmo <= r_tmo + 1'b1;
          // Completion is checked first so it wins over a coincident timeout.
          if (r_beats == r_len) begin
            r_gap   <= '0;
            r_state <= S_GAP;
            if (r_run_cnt != 8'hFF) r_run_cnt <= r_run_cnt + 8'd1;
          end else if (r_tmo == TMO_LAST) begin
            r_err_timeout <= 1'b1;
            r_pass        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GAP_LAST) begin
            if (r_iter < w_iter_last) begin
              r_iter      <= r_iter + 4'd1;
              r_patgen_en <= 1'b1;
              r_state     <= S_LAUNCH;
            end else begin
              r_iter <= 4'd0;
              if (w_next[2]) begin
                r_mode       <= w_next[1:0];
                r_patgen_sel <= w_next[1:0];
                r_patgen_en  <= 1'b1;
                r_state      <= S_LAUNCH;
              end else begin
                // A checker pulse in this very cycle still counts.
                r_pass  <= !(r_chk_err || chkr_err) && !r_err_timeout;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign patgen_en   = r_patgen_en;
  assign patgen_sel  = r_patgen_sel;
  assign patgen_cnt  = r_patgen_cnt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_timeout = r_err_timeout;
  assign err_cfg     = r_err_cfg;
  assign run_cnt     = r_run_cnt;

endmodule

// File: tb/tb_axi_mm_test_seq.sv
// Directed bench for the AXI-Stream test sequencer.
module tb_axi_mm_test_seq;

  logic       wr_clk;
  logic       rst_n;
  logic       start;
  logic [2:0] mode_mask;
  logic [7:0] burst_len;
  logic [3:0] num_iter;
  logic       axist_valid;
  logic       axist_rdy;
  logic       chkr_err;
  logic       patgen_en;
  logic [1:0] patgen_sel;
  logic [7:0] patgen_cnt;
  logic       busy;
  logic       done;
  logic       pass;
  logic       err_timeout;
  logic       err_cfg;
  logic [7:0] run_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side stimulus state.
  logic rdy_lvl = 1'b1;
  logic rdy_tog = 1'b0;
  logic ph      = 1'b0;
  assign axist_rdy = rdy_tog ? ph : rdy_lvl;

  axi_mm_test_seq #(.TIMEOUT_CYC(1024), .GAP_CYC(4)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .start(start), .mode_mask(mode_mask),
    .burst_len(burst_len), .num_iter(num_iter), .axist_valid(axist_valid),
    .axist_rdy(axist_rdy), .chkr_err(chkr_err), .patgen_en(patgen_en),
    .patgen_sel(patgen_sel), .patgen_cnt(patgen_cnt), .busy(busy), .done(done),
    .pass(pass), .err_timeout(err_timeout), .err_cfg(err_cfg), .run_cnt(run_cnt)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  // Monitor: event logs sampled on the falling edge.
  int         en_cnt = 0;
  int         en_cyc [64];
  logic [1:0] sel_log [64];
  logic [7:0] cnt_log [64];
  int         rinc_cnt = 0;
  int         rinc_cyc [64];
  logic [7:0] prev_run = 8'd0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_pass = 1'b0;
  logic [7:0] done_runs = 8'd0;

  always @(negedge wr_clk) begin
    if (patgen_en) begin
      en_cyc[en_cnt % 64]  = cyc;
      sel_log[en_cnt % 64] = patgen_sel;
      cnt_log[en_cnt % 64] = patgen_cnt;
      en_cnt++;
    end
    if (run_cnt == prev_run + 8'd1) begin
      rinc_cyc[rinc_cnt % 64] = cyc;
      rinc_cnt++;
    end
    prev_run = run_cnt;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_pass = pass;
      done_runs = run_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
    ph = ~ph;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic [7:0] b, input logic [3:0] it);
    mode_mask = m; burst_len = b; num_iter = it; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    if (done_cnt == base) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_en(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (en_cnt < target && k < budget) begin
      tick();
      k++;
    end
    if (en_cnt < target) check({tag, "_en_timeout"}, en_cnt, target);
  endtask

  logic [23:0] all_out;
  assign all_out = {patgen_en, patgen_sel, patgen_cnt, busy, done, pass,
                    err_timeout, err_cfg, run_cnt};

  int eb, rb, db, sc;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_mask = 3'd0; burst_len = 8'd0;
    num_iter = 4'd0; axist_valid = 1'b1; chkr_err = 1'b0;
    ticks(3);
    check("reset_outputs", all_out, 24'd0);
    rst_n = 1'b1;
    ticks(2);

    // Three modes, one run each, config changed right after start.
    eb = en_cnt; rb = rinc_cnt;
    rdy_lvl = 1'b1; rdy_tog = 1'b0;
    pulse_start(3'b111, 8'd8, 4'd1);
    check("t1_busy", busy, 1);
    mode_mask = 3'b000; burst_len = 8'd1; num_iter = 4'd9;
    wait_done("t1", 200);
    check("t1_en_pulses", en_cnt - eb, 3);
    check("t1_sel0", sel_log[eb % 64], 0);
    check("t1_sel1", sel_log[(eb + 1) % 64], 1);
    check("t1_sel2", sel_log[(eb + 2) % 64], 2);
    check("t1_cnt", cnt_log[eb % 64], 8);
    check("t1_run_len", rinc_cyc[rb % 64] - en_cyc[eb % 64], 10);
    check("t1_pass", done_pass, 1);
    check("t1_run_cnt", done_runs, 3);
    tick();
    check("t1_idle_busy", busy, 0);

    // Incrementing mode only, three iterations, ready toggling.
    eb = en_cnt; rb = rinc_cnt;
    rdy_tog = 1'b1;
    pulse_start(3'b100, 8'd4, 4'd3);
    wait_done("t2", 300);
    rdy_tog = 1'b0;
    check("t2_en_pulses", en_cnt - eb, 3);
    check("t2_sel_a", sel_log[eb % 64], 2);
    check("t2_sel_c", sel_log[(eb + 2) % 64], 2);
    check("t2_gap1", en_cyc[(eb + 1) % 64] - rinc_cyc[rb % 64], 4);
    check("t2_gap2", en_cyc[(eb + 2) % 64] - rinc_cyc[(rb + 1) % 64], 4);
    check("t2_pass", done_pass, 1);
    check("t2_run_cnt", done_runs, 3);
    tick();

    // Random mode with ready stuck low: timeout.
    eb = en_cnt;
    rdy_lvl = 1'b0;
    pulse_start(3'b010, 8'd16, 4'd1);
    wait_done("t3", 1200);
    check("t3_err_timeout", err_timeout, 1);
    check("t3_timeout_cycles", done_cyc - en_cyc[eb % 64], 1025);
    check("t3_pass", done_pass, 0);
    check("t3_run_cnt", done_runs, 0);
    check("t3_en_pulses", en_cnt - eb, 1);
    rdy_lvl = 1'b1;
    tick();

    // Illegal configurations.
    eb = en_cnt; db = done_cnt;
    sc = cyc;
    pulse_start(3'b000, 8'd8, 4'd1);
    ticks(2);
    check("t4a_done_lat", done_cyc - sc, 1);
    check("t4a_err_cfg", err_cfg, 1);
    check("t4a_err_timeout_clr", err_timeout, 0);
    check("t4a_pass", done_pass, 0);
    sc = cyc;
    pulse_start(3'b111, 8'd0, 4'd1);
    ticks(2);
    check("t4b_done_cnt", done_cnt - db, 2);
    check("t4b_done_lat", done_cyc - sc, 1);
    check("t4b_err_cfg", err_cfg, 1);
    check("t4_no_en", en_cnt - eb, 0);

    // Checker error in second run plus a start while busy.
    eb = en_cnt; db = done_cnt;
    pulse_start(3'b001, 8'd8, 4'd2);
    check("t5_err_cfg_clr", err_cfg, 0);
    wait_en("t5", eb + 2, 100);
    ticks(3);
    chkr_err = 1'b1;
    tick();
    chkr_err = 1'b0;
    pulse_start(3'b111, 8'd8, 4'd1);
    wait_done("t5", 200);
    check("t5_run_cnt", done_runs, 2);
    check("t5_pass", done_pass, 0);
    ticks(30);
    check("t5_en_pulses", en_cnt - eb, 2);
    check("t5_done_cnt", done_cnt - db, 1);

    // Reset in WAIT, then immediate restart.
    eb = en_cnt; db = done_cnt;
    pulse_start(3'b111, 8'd8, 4'd1);
    wait_en("t6", eb + 1, 20);
    ticks(3);
    rst_n = 1'b0;
    tick();
    check("t6_reset_outputs", all_out, 24'd0);
    tick();
    check("t6_reset_hold", all_out, 24'd0);
    check("t6_no_done", done_cnt - db, 0);
    eb = en_cnt;
    rst_n = 1'b1;
    pulse_start(3'b111, 8'd8, 4'd1);
    check("t6_restart_busy", busy, 1);
    wait_done("t6", 200);
    check("t6_en_pulses", en_cnt - eb, 3);
    check("t6_pass", done_pass, 1);
    check("t6_run_cnt", done_runs, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
